// File: rtl/addsub_seq_ctrl_if.sv
// Bundle between the calculator front end, the add/sub sequencer and the
// external narrow adder slice.
interface addsub_seq_ctrl_if #(
    parameter int SLICE_W = 4,
    parameter int SLICES  = 2
);
    localparam int W = SLICE_W * SLICES;

    logic               start;
    logic               op;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic               slice_cin;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic               busy;
    logic               done;
    logic [W-1:0]       result;
    logic               cout;
    logic               ovf;
    logic               zero;
    logic               neg;

    modport master (
        output start, op, a, b, slice_s, slice_cout,
        input  slice_a, slice_b, slice_cin,
        input  busy, done, result, cout, ovf, zero, neg
    );

    modport slave (
        input  start, op, a, b, slice_s, slice_cout,
        output slice_a, slice_b, slice_cin,
        output busy, done, result, cout, ovf, zero, neg
    );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Signed add/subtract sequenced through one external narrow adder slice,
// least significant slice first, with carry chained through a register.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on acceptance
//   RUN   | one slice per cycle through the external adder
//   DONE  | one-cycle done pulse; result and flags valid
module addsub_seq_ctrl #(
    parameter int SLICE_W = 4,
    parameter int SLICES  = 2
) (
    input logic               clk,
    input logic               rst,
    addsub_seq_ctrl_if.slave  bus
);
    localparam int W     = SLICE_W * SLICES;
    localparam int CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic         op_reg;
    logic         carry;
    logic [W-1:0] acc;
    logic         busy_r;
    logic         done_r;
    logic [W-1:0] result_r;
    logic         cout_r;
    logic         ovf_r;
    logic         zero_r;
    logic         neg_r;

    logic [W-1:0] acc_next;
    logic [W-1:0] b_eff;
    logic         ovf_next;
    logic         run;

    assign run = (state == RUN);

    always_comb begin
        acc_next = acc;
        acc_next[cnt*SLICE_W +: SLICE_W] = bus.slice_s;
        b_eff    = b_reg ^ {W{op_reg}};
        ovf_next = (a_reg[W-1] == b_eff[W-1]) && (acc_next[W-1] != a_reg[W-1]);
    end

    assign bus.slice_a   = run ? a_reg[cnt*SLICE_W +: SLICE_W] : '0;
    assign bus.slice_b   = run ? (b_reg[cnt*SLICE_W +: SLICE_W] ^ {SLICE_W{op_reg}}) : '0;
    assign bus.slice_cin = run ? carry : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= 1'b0;
            carry    <= 1'b0;
            acc      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.a;
                        b_reg  <= bus.b;
                        op_reg <= bus.op;
                        carry  <= bus.op;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= bus.slice_cout;
                    if (cnt == CNT_W'(SLICES-1)) begin
                        // Flags are loaded with the final slice so they are
                        // valid in the same cycle as the done pulse.
                        result_r <= acc_next;
                        cout_r   <= bus.slice_cout;
                        ovf_r    <= ovf_next;
                        zero_r   <= (acc_next == '0);
                        neg_r    <= acc_next[W-1];
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.cout   = cout_r;
    assign bus.ovf    = ovf_r;
    assign bus.zero   = zero_r;
    assign bus.neg    = neg_r;
endmodule
